// File: rtl/range_tracker_if.sv
// Sample-stream and result bundle for range_tracker; the tracker sits on the
// slave side, the sample source / result consumer on the master side.
interface range_tracker_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
);
    logic [WIDTH-1:0] data_in;
    logic             valid;
    logic             go;
    logic             finish;
    logic [WIDTH:0]   range_out;
    logic [WIDTH-1:0] min_out;
    logic [WIDTH-1:0] max_out;
    logic [CNT_W-1:0] count_out;
    logic             count_sat;
    logic             done;
    logic             busy;
    logic             err_seq;
    logic             err_restart;

    modport master (
        output data_in, valid, go, finish,
        input  range_out, min_out, max_out, count_out, count_sat,
        input  done, busy, err_seq, err_restart
    );

    modport slave (
        input  data_in, valid, go, finish,
        output range_out, min_out, max_out, count_out, count_sat,
        output done, busy, err_seq, err_restart
    );
endinterface

// File: rtl/range_tracker.sv
// Tracks min, max and sample count over a go/finish-delimited session and
// publishes them with a one-cycle done pulse when the session closes.
module range_tracker #(
    parameter int WIDTH  = 8,
    parameter int CNT_W  = 8,
    parameter int SIGNED = 0
) (
    input logic           clock,
    input logic           reset,
    range_tracker_if.slave bus
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [0:0]       state;
    logic [WIDTH-1:0] cur_min;
    logic [WIDTH-1:0] cur_max;
    logic [CNT_W-1:0] cur_cnt;
    logic             cur_sat;

    logic [WIDTH-1:0] fold_min;
    logic [WIDTH-1:0] fold_max;
    logic [CNT_W-1:0] fold_cnt;
    logic             fold_sat;
    logic [WIDTH:0]   fold_range;

    // One extra bit lets signed and unsigned samples share one signed compare
    // and keeps max - min from ever wrapping.
    function automatic logic [WIDTH:0] ext(input logic [WIDTH-1:0] x);
        return (SIGNED != 0) ? {x[WIDTH-1], x} : {1'b0, x};
    endfunction

    // Session state with the current sample folded in.
    always_comb begin
        fold_min = cur_min;
        fold_max = cur_max;
        if ($signed(ext(bus.data_in)) < $signed(ext(cur_min)))
            fold_min = bus.data_in;
        if ($signed(ext(bus.data_in)) > $signed(ext(cur_max)))
            fold_max = bus.data_in;
        fold_cnt   = (cur_cnt == CNT_MAX) ? cur_cnt : cur_cnt + CNT_ONE;
        fold_sat   = cur_sat | (cur_cnt == CNT_MAX);
        fold_range = ext(fold_max) - ext(fold_min);
    end

    assign bus.busy = (state == RUN);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            cur_min         <= '0;
            cur_max         <= '0;
            cur_cnt         <= '0;
            cur_sat         <= 1'b0;
            bus.range_out   <= '0;
            bus.min_out     <= '0;
            bus.max_out     <= '0;
            bus.count_out   <= '0;
            bus.count_sat   <= 1'b0;
            bus.done        <= 1'b0;
            bus.err_seq     <= 1'b0;
            bus.err_restart <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.go) begin
                        bus.err_seq     <= 1'b0;
                        bus.err_restart <= 1'b0;
                        if (bus.finish) begin
                            bus.min_out   <= bus.data_in;
                            bus.max_out   <= bus.data_in;
                            bus.range_out <= '0;
                            bus.count_out <= CNT_ONE;
                            bus.count_sat <= 1'b0;
                            bus.done      <= 1'b1;
                        end else begin
                            cur_min <= bus.data_in;
                            cur_max <= bus.data_in;
                            cur_cnt <= CNT_ONE;
                            cur_sat <= 1'b0;
                            state   <= RUN;
                        end
                    end else if (bus.finish) begin
                        bus.err_seq <= 1'b1;
                    end
                end
                default: begin
                    if (bus.finish) begin
                        bus.min_out   <= fold_min;
                        bus.max_out   <= fold_max;
                        bus.range_out <= fold_range;
                        bus.count_out <= fold_cnt;
                        bus.count_sat <= fold_sat;
                        bus.done      <= 1'b1;
                        cur_min       <= '0;
                        cur_max       <= '0;
                        cur_cnt       <= '0;
                        cur_sat       <= 1'b0;
                        state         <= IDLE;
                        if (bus.go)
                            bus.err_restart <= 1'b1;
                    end else if (bus.go) begin
                        bus.err_restart <= 1'b1;
                        cur_min         <= bus.data_in;
                        cur_max         <= bus.data_in;
                        cur_cnt         <= CNT_ONE;
                        cur_sat         <= 1'b0;
                    end else if (bus.valid) begin
                        cur_min <= fold_min;
                        cur_max <= fold_max;
                        cur_cnt <= fold_cnt;
                        cur_sat <= fold_sat;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_range_tracker.sv
// Drives unsigned, signed and narrow-counter trackers with the same stream and
// checks them against a queue-based session model.
module tb_range_tracker;
    logic clock;
    logic reset;

    range_tracker_if #(.WIDTH(8), .CNT_W(8)) bus_u ();
    range_tracker_if #(.WIDTH(8), .CNT_W(8)) bus_s ();
    range_tracker_if #(.WIDTH(8), .CNT_W(2)) bus_n ();

    range_tracker #(.WIDTH(8), .CNT_W(8), .SIGNED(0)) dut_u (.clock(clock), .reset(reset), .bus(bus_u));
    range_tracker #(.WIDTH(8), .CNT_W(8), .SIGNED(1)) dut_s (.clock(clock), .reset(reset), .bus(bus_s));
    range_tracker #(.WIDTH(8), .CNT_W(2), .SIGNED(0)) dut_n (.clock(clock), .reset(reset), .bus(bus_n));

    int checks = 0;
    int failures = 0;

    logic [7:0] samples[$];
    bit         m_open, m_done, m_err_seq, m_err_restart;
    logic [7:0] e_min_u, e_max_u, e_min_s, e_max_s, e_cnt8;
    logic [8:0] e_rng_u, e_rng_s;
    logic [1:0] e_cnt2;
    bit         e_sat8, e_sat2;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        samples.delete();
        m_open = 0; m_done = 0; m_err_seq = 0; m_err_restart = 0;
        e_min_u = 0; e_max_u = 0; e_min_s = 0; e_max_s = 0;
        e_rng_u = 0; e_rng_s = 0; e_cnt8 = 0; e_sat8 = 0; e_cnt2 = 0; e_sat2 = 0;
    endtask

    // Results of a closed session, from the raw list of its samples.
    task automatic modelPublish();
        int mn_u, mx_u, mn_s, mx_s, v_u, v_s, n;
        mn_u = int'(samples[0]); mx_u = mn_u;
        mn_s = int'($signed(samples[0])); mx_s = mn_s;
        foreach (samples[i]) begin
            v_u = int'(samples[i]);
            v_s = int'($signed(samples[i]));
            if (v_u < mn_u) mn_u = v_u;
            if (v_u > mx_u) mx_u = v_u;
            if (v_s < mn_s) mn_s = v_s;
            if (v_s > mx_s) mx_s = v_s;
        end
        n = samples.size();
        e_min_u = 8'(mn_u); e_max_u = 8'(mx_u); e_rng_u = 9'(mx_u - mn_u);
        e_min_s = 8'(mn_s); e_max_s = 8'(mx_s); e_rng_s = 9'(mx_s - mn_s);
        e_cnt8 = 8'((n > 255) ? 255 : n); e_sat8 = (n > 255);
        e_cnt2 = 2'((n > 3) ? 3 : n);     e_sat2 = (n > 3);
        m_done = 1;
    endtask

    task automatic modelStep(input bit go, input bit finish, input bit valid, input logic [7:0] data);
        m_done = 0;
        if (!m_open) begin
            if (go) begin
                m_err_seq = 0; m_err_restart = 0;
                samples.delete();
                samples.push_back(data);
                if (finish) modelPublish();
                else m_open = 1;
            end else if (finish) begin
                m_err_seq = 1;
            end
        end else if (finish) begin
            samples.push_back(data);
            modelPublish();
            m_open = 0;
            if (go) m_err_restart = 1;
        end else if (go) begin
            m_err_restart = 1;
            samples.delete();
            samples.push_back(data);
        end else if (valid) begin
            samples.push_back(data);
        end
    endtask

    task automatic checkOutput();
        checkValue("u.done", bus_u.done, m_done);
        checkValue("s.done", bus_s.done, m_done);
        checkValue("n.done", bus_n.done, m_done);
        checkValue("u.busy", bus_u.busy, m_open);
        checkValue("n.busy", bus_n.busy, m_open);
        checkValue("u.err_seq", bus_u.err_seq, m_err_seq);
        checkValue("s.err_seq", bus_s.err_seq, m_err_seq);
        checkValue("u.err_restart", bus_u.err_restart, m_err_restart);
        checkValue("s.err_restart", bus_s.err_restart, m_err_restart);
        checkValue("u.min", bus_u.min_out, e_min_u);
        checkValue("u.max", bus_u.max_out, e_max_u);
        checkValue("u.range", bus_u.range_out, e_rng_u);
        checkValue("u.count", bus_u.count_out, e_cnt8);
        checkValue("u.sat", bus_u.count_sat, e_sat8);
        checkValue("s.min", bus_s.min_out, e_min_s);
        checkValue("s.max", bus_s.max_out, e_max_s);
        checkValue("s.range", bus_s.range_out, e_rng_s);
        checkValue("s.count", bus_s.count_out, e_cnt8);
        checkValue("n.min", bus_n.min_out, e_min_u);
        checkValue("n.max", bus_n.max_out, e_max_u);
        checkValue("n.range", bus_n.range_out, e_rng_u);
        checkValue("n.count", bus_n.count_out, e_cnt2);
        checkValue("n.sat", bus_n.count_sat, e_sat2);
    endtask

    task automatic driveInputs(input bit go, input bit finish, input bit valid, input logic [7:0] data);
        bus_u.go = go; bus_u.finish = finish; bus_u.valid = valid; bus_u.data_in = data;
        bus_s.go = go; bus_s.finish = finish; bus_s.valid = valid; bus_s.data_in = data;
        bus_n.go = go; bus_n.finish = finish; bus_n.valid = valid; bus_n.data_in = data;
    endtask

    // One clock of stimulus; outputs are checked 1 time unit after the edge.
    task automatic applyStimulus(input bit go, input bit finish, input bit valid, input logic [7:0] data);
        driveInputs(go, finish, valid, data);
        @(posedge clock);
        #1;
        modelStep(go, finish, valid, data);
        checkOutput();
    endtask

    task automatic checkAllZero(input string tag);
        checkValue({tag, ".u"}, {bus_u.range_out, bus_u.min_out, bus_u.max_out, bus_u.count_out, bus_u.count_sat,
                                 bus_u.done, bus_u.busy, bus_u.err_seq, bus_u.err_restart}, 32'd0);
        checkValue({tag, ".s"}, {bus_s.range_out, bus_s.min_out, bus_s.max_out, bus_s.count_out, bus_s.count_sat,
                                 bus_s.done, bus_s.busy, bus_s.err_seq, bus_s.err_restart}, 32'd0);
        checkValue({tag, ".n"}, {bus_n.range_out, bus_n.min_out, bus_n.max_out, bus_n.count_out, bus_n.count_sat,
                                 bus_n.done, bus_n.busy, bus_n.err_seq, bus_n.err_restart}, 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        driveInputs(0, 0, 0, 8'd0);
        modelReset();
        #12;
        checkAllZero("reset_state");
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;

        // Unsigned session 50,20,200,90,10.
        applyStimulus(1, 0, 0, 8'd50);
        checkValue("plan1.busy_up", bus_u.busy, 1'b1);
        applyStimulus(0, 0, 1, 8'd20);
        applyStimulus(0, 0, 1, 8'd200);
        applyStimulus(0, 0, 1, 8'd90);
        applyStimulus(0, 1, 0, 8'd10);
        checkValue("plan1.min", bus_u.min_out, 8'd10);
        checkValue("plan1.max", bus_u.max_out, 8'd200);
        checkValue("plan1.range", bus_u.range_out, 9'd190);
        checkValue("plan1.count", bus_u.count_out, 8'd5);
        checkValue("plan1.done", {bus_u.done, bus_u.busy}, 2'b10);
        applyStimulus(0, 0, 0, 8'd0);
        checkValue("plan1.done_drop", bus_u.done, 1'b0);

        // Signed session -100, 127, 0.
        applyStimulus(1, 0, 0, 8'h9C);
        applyStimulus(0, 0, 1, 8'd127);
        applyStimulus(0, 1, 0, 8'd0);
        checkValue("plan2.min", bus_s.min_out, 8'h9C);
        checkValue("plan2.max", bus_s.max_out, 8'd127);
        checkValue("plan2.range", bus_s.range_out, 9'h0E3);
        checkValue("plan2.count", bus_s.count_out, 8'd3);

        // finish with no session open.
        applyStimulus(0, 1, 0, 8'd33);
        checkValue("plan3.err_seq", {bus_u.err_seq, bus_u.done}, 2'b10);
        checkValue("plan3.held", bus_u.min_out, 8'd0);
        applyStimulus(0, 0, 0, 8'd0);

        // Restart mid-session, then a single-cycle session.
        applyStimulus(1, 0, 0, 8'd5);
        applyStimulus(0, 0, 1, 8'd9);
        checkValue("plan4.err_seq_clear", bus_u.err_seq, 1'b0);
        applyStimulus(1, 0, 0, 8'd40);
        applyStimulus(0, 1, 0, 8'd41);
        checkValue("plan4.err_restart", bus_u.err_restart, 1'b1);
        checkValue("plan4.result", {bus_u.min_out, bus_u.max_out, bus_u.count_out}, {8'd40, 8'd41, 8'd2});
        checkValue("plan4.range", bus_u.range_out, 9'd1);
        applyStimulus(1, 1, 0, 8'd77);
        checkValue("plan4.single", {bus_u.min_out, bus_u.max_out, bus_u.count_out, bus_u.done}, {8'd77, 8'd77, 8'd1, 1'b1});
        checkValue("plan4.single_range", bus_u.range_out, 9'd0);

        // Counter saturation on the narrow instance, with idle gaps.
        applyStimulus(1, 0, 0, 8'd60);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 0, 1, 8'(61 + i));
            applyStimulus(0, 0, 0, 8'd255);
        end
        applyStimulus(0, 1, 0, 8'd62);
        checkValue("plan5.count", bus_n.count_out, 2'd3);
        checkValue("plan5.sat", bus_n.count_sat, 1'b1);
        checkValue("plan5.max", bus_n.max_out, 8'd65);

        // Back-to-back sessions: go right after finish.
        applyStimulus(1, 0, 0, 8'd3);
        applyStimulus(0, 1, 0, 8'd4);
        applyStimulus(1, 0, 0, 8'd8);
        applyStimulus(0, 0, 1, 8'd2);

        // Asynchronous reset while busy.
        #2;
        reset = 1'b1;
        #1;
        modelReset();
        checkAllZero("async_reset");
        @(negedge clock);
        reset = 1'b0;
        applyStimulus(1, 0, 0, 8'd11);
        applyStimulus(0, 1, 0, 8'd22);
        checkValue("post_reset.range", bus_u.range_out, 9'd11);

        // Randomised sessions.
        for (int i = 0; i < 600; i++) begin
            int r_go, r_fin;
            r_go  = $urandom_range(0, 99);
            r_fin = $urandom_range(0, 99);
            applyStimulus(r_go < 12, r_fin < 12, $urandom_range(0, 99) < 65, 8'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/range_tracker.md
# range_tracker

Parametrised successor to the 8-bit range finder. Tracks running minimum, maximum and sample count of a gated sample stream over a go/finish-delimited session. At session end it publishes min, max, range (max − min) and count with a one-cycle done pulse. Adds configurable width, signed mode, a sample-valid qualifier, a saturating counter and distinct error flags; sits directly on the chip I/O pins or behind a pin-mux wrapper.

## Interface
- WIDTH, 8: sample width in bits (≥ 2)
- CNT_W, 8: sample-counter width in bits (≥ 2)
- SIGNED, 0: 1 = samples are two's complement, 0 = unsigned
- clock  in  1  system clock, rising edge
- reset  in  1  reset, asynchronous, active-high
- data_in  in  WIDTH  sample
- valid  in  1  data_in is a sample this cycle (RUN state only)
- go  in  1  start session; the go-cycle data_in is the first sample
- finish  in  1  end session; the finish-cycle data_in is the last sample
- range_out  out  WIDTH+1  max − min of last completed session, unsigned
- min_out / max_out  out  WIDTH  extremes of last completed session
- count_out  out  CNT_W  samples in last completed session, saturating
- count_sat  out  1  count_out saturated in last completed session
- done  out  1  one-cycle pulse: result outputs just updated
- busy  out  1  session in progress (state == RUN)
- err_seq  out  1  sticky: finish seen with no session open
- err_restart  out  1  sticky: go seen while a session was open

## Operation
- Reset: state IDLE; every output and internal register is 0.
- Internal registers: cur_min, cur_max (WIDTH), cur_cnt (CNT_W), cur_sat.
- Comparisons are signed when SIGNED=1, otherwise unsigned. range = max − min, computed in WIDTH+1 bits with sign extension when SIGNED=1 and zero extension when SIGNED=0. The result is always non-negative and never wraps.
- IDLE, go=1, finish=0: cur_min = cur_max = data_in, cur_cnt = 1, cur_sat = 0; go to RUN. Clear err_seq and err_restart.
- IDLE, go=1, finish=1: single-sample session. Publish min = max = data_in, range = 0, count = 1, sat = 0; pulse done; stay in IDLE. Clear both error flags.
- IDLE, go=0, finish=1: set err_seq; results unchanged; no done pulse.
- IDLE, go=0, finish=0: hold.
- RUN, finish=1, go=0: fold data_in into the session unconditionally (valid is ignored). Publish min, max, range, count and sat from the folded values; pulse done; go to IDLE; clear cur_*.
- RUN, go=1, finish=0: set err_restart and discard the open session. Restart with data_in as the first sample (cur_cnt = 1); stay in RUN; no done pulse.
- RUN, go=1, finish=1: treat as finish; set err_restart.
- RUN, neither, valid=1: update cur_min/cur_max where data_in is a new extreme, and increment cur_cnt. If cur_cnt is already 2^CNT_W − 1, hold it and set cur_sat.
- RUN, neither, valid=0: hold.
- Folding is identical in all cases: the new extremes include data_in before range is computed.

## Timing
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Result latency is 1 cycle. Results and done become visible after the rising edge that samples finish; done is high for exactly that one cycle.
- Result outputs hold until the next published session or reset.
- busy rises on the edge that samples go and falls on the edge that samples finish.
- Back-to-back sessions are allowed. go in the cycle immediately after finish starts a new session; done from the previous session still pulses in that cycle.
- An asynchronous reset mid-session drops the session, clears all outputs and clears the error flags.

## Test plan
- WIDTH=8, unsigned: go with 50, then valid samples 20, 200, 90, then finish with 10 → min 10, max 200, range 190, count 5, done for 1 cycle, busy 1→0.
- SIGNED=1, WIDTH=8: go with −100, valid 127, finish with 0 → min −100 (0x9C), max 127, range 227 (0x0E3 in 9 bits), count 3.
- finish asserted in IDLE → err_seq=1, outputs unchanged, no done. The next go clears err_seq.
- go in RUN after samples 5, 9 with data 40, then finish with 41 → err_restart=1, min 40, max 41, range 1, count 2. go and finish together in IDLE with 77 → min = max = 77, range 0, count 1, done.
- CNT_W=2: go, then 5 valid samples, then finish → count_out 3, count_sat 1. valid=0 cycles in between do not change min, max or count.
- Assert reset while busy → all outputs 0 immediately. After release, a fresh go/finish session behaves normally.
